// File: rtl/spi_cmd_rx.sv
// SPI mode-0 slave byte receiver with a show-ahead FIFO on a valid/ready output.
// Define SPI_RX_OVF_CNT_EN to add the saturating ovf_count error counter port.
`timescale 1ns/1ps
module spi_cmd_rx #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    CS,
  input  logic                    SCK,
  input  logic                    MOSI,
  output logic [7:0]              rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    frame_err,
  output logic                    ovf,
`ifdef SPI_RX_OVF_CNT_EN
  output logic [7:0]              ovf_count,
`endif
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  localparam logic [1:0] WAIT_IDLE = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] SHIFT     = 2'd2;

  logic [2:0]    cs_sync_q, cs_sync_d;
  logic [2:0]    sck_sync_q, sck_sync_d;
  logic [1:0]    mosi_sync_q, mosi_sync_d;
  logic [1:0]    prime_q, prime_d;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          frame_err_q, frame_err_d;
  logic          ovf_q, ovf_d;

  logic          cs_s, cs_rise, cs_fall, sck_rise, mosi_s;
  logic          push_req, push_ok, pop, full;
  logic [7:0]    push_byte;

  always_comb begin
    cs_sync_d   = {cs_sync_q[1:0], CS};
    sck_sync_d  = {sck_sync_q[1:0], SCK};
    mosi_sync_d = {mosi_sync_q[0], MOSI};
    prime_d     = {prime_q[0], 1'b1};
    cs_s        = cs_sync_q[1];
    cs_rise     = cs_sync_q[1] & ~cs_sync_q[2];
    cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
    sck_rise    = sck_sync_q[1] & ~sck_sync_q[2];
    mosi_s      = mosi_sync_q[1];
  end

  // WAIT_IDLE also waits for prime_q so the synchronizer's reset value of CS
  // is never mistaken for a real high level followed by a falling edge.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push_req    = 1'b0;
    push_byte   = {shift_q[6:0], mosi_s};
    frame_err_d = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (prime_q[1] && cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          bit_cnt_d = 3'd0;
          shift_d   = 8'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != 3'd0);
        end else if (sck_rise) begin
          shift_d   = push_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          push_req  = (bit_cnt_q == 3'd7);
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // only dropped when nothing is being consumed.
  always_comb begin
    pop      = (level_q != '0) && rx_ready;
    full     = (level_q == FULL_LEVEL);
    push_ok  = push_req && (!full || pop);
    ovf_d    = push_req && full && !pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_byte;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= 3'b111;
      sck_sync_q  <= 3'b000;
      mosi_sync_q <= 2'b00;
      prime_q     <= 2'b00;
      state_q     <= WAIT_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      prime_q     <= prime_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef SPI_RX_OVF_CNT_EN
  logic [7:0] ovf_count_q, ovf_count_d;

  always_comb begin
    ovf_count_d = ovf_count_q;
    if ((ovf_q || frame_err_q) && (ovf_count_q != 8'hFF))
      ovf_count_d = ovf_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_count_q <= 8'd0;
    else        ovf_count_q <= ovf_count_d;
  end

  assign ovf_count = ovf_count_q;
`endif

  assign rx_data   = mem_q[rd_ptr_q];
  assign rx_valid  = (level_q != '0);
  assign level     = level_q;
  assign frame_err = frame_err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Directed bench for spi_cmd_rx: SPI frames bit-banged on clk-aligned phases,
// FIFO contents and error pulses compared against hand-computed values.
`timescale 1ns/1ps
module tb_spi_cmd_rx;

  logic       clk;
  logic       rst_n;
  logic       CS;
  logic       SCK;
  logic       MOSI;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       ovf;
  logic [2:0] level;
`ifdef SPI_RX_OVF_CNT_EN
  logic [7:0] ovf_count;
`endif

  int         vectors;
  int         miscompares;
  int         validCycles;
  int         frameErrCycles;
  int         ovfCycles;
  logic [7:0] lastPop;

  spi_cmd_rx #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .CS        (CS),
    .SCK       (SCK),
    .MOSI      (MOSI),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .ovf       (ovf),
`ifdef SPI_RX_OVF_CNT_EN
    .ovf_count (ovf_count),
`endif
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse and handshake activity is tallied on the falling edge, away from
  // the sampling edge of the design.
  always @(negedge clk) begin
    if (rx_valid) validCycles++;
    if (frame_err) frameErrCycles++;
    if (ovf) ovfCycles++;
    if (rx_valid && rx_ready) lastPop = rx_data;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearMonitor();
    validCycles    = 0;
    frameErrCycles = 0;
    ovfCycles      = 0;
    lastPop        = 8'h00;
  endtask

  // 40 ns SPI phase, always ending 2 ns after a rising clk edge.
  task automatic halfPhase();
    repeat (4) @(posedge clk);
    #2;
  endtask

  // Sends the top nBits of b MSB-first, leaving SCK low.
  task automatic applyStimulus(input logic [7:0] b, input int nBits);
    for (int i = 7; i > 7 - nBits; i--) begin
      MOSI = b[i];
      halfPhase();
      SCK = 1'b1;
      halfPhase();
      SCK = 1'b0;
    end
  endtask

  task automatic startFrame();
    CS = 1'b0;
    halfPhase();
  endtask

  task automatic endFrame();
    halfPhase();
    CS = 1'b1;
    repeat (8) @(posedge clk);
    #2;
  endtask

  task automatic popOne();
    rx_ready = 1'b1;
    @(posedge clk);
    #2;
    rx_ready = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clearMonitor();
    rst_n    = 1'b0;
    CS       = 1'b1;
    SCK      = 1'b0;
    MOSI     = 1'b0;
    rx_ready = 1'b0;
    #22;
    checkOutput("rst_rx_data", 32'(rx_data), 32'h00);
    checkOutput("rst_rx_valid", 32'(rx_valid), 32'h0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'h0);
    checkOutput("rst_ovf", 32'(ovf), 32'h0);
    checkOutput("rst_level", 32'(level), 32'h0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #2;

    $display("[TB] single byte 0x02 with rx_ready held");
    rx_ready = 1'b1;
    clearMonitor();
    startFrame();
    applyStimulus(8'h02, 8);
    endFrame();
    checkOutput("t1_valid_cycles", 32'(validCycles), 32'd1);
    checkOutput("t1_data", 32'(lastPop), 32'h02);
    checkOutput("t1_frame_err", 32'(frameErrCycles), 32'd0);
    checkOutput("t1_ovf", 32'(ovfCycles), 32'd0);
    rx_ready = 1'b0;

    $display("[TB] two bytes in one frame, then drain");
    startFrame();
    applyStimulus(8'hA5, 8);
    applyStimulus(8'h3C, 8);
    endFrame();
    checkOutput("t2_level", 32'(level), 32'd2);
    checkOutput("t2_head", 32'(rx_data), 32'hA5);
    rx_ready = 1'b1;
    @(negedge clk);
    checkOutput("t2_pop0", 32'(rx_data), 32'hA5);
    @(negedge clk);
    checkOutput("t2_pop1", 32'(rx_data), 32'h3C);
    checkOutput("t2_pop1_valid", 32'(rx_valid), 32'h1);
    @(negedge clk);
    checkOutput("t2_empty_valid", 32'(rx_valid), 32'h0);
    checkOutput("t2_empty_level", 32'(level), 32'd0);
    @(posedge clk);
    #2;
    rx_ready = 1'b0;

    $display("[TB] overrun with five bytes into depth four");
    clearMonitor();
    startFrame();
    applyStimulus(8'h11, 8);
    applyStimulus(8'h22, 8);
    applyStimulus(8'h33, 8);
    applyStimulus(8'h44, 8);
    applyStimulus(8'h55, 8);
    endFrame();
    checkOutput("t3_level", 32'(level), 32'd4);
    checkOutput("t3_ovf_cycles", 32'(ovfCycles), 32'd1);
`ifdef SPI_RX_OVF_CNT_EN
    checkOutput("t3_ovf_count", 32'(ovf_count), 32'd1);
`endif
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t3_drain%0d", i), 32'(rx_data), 32'h11 * (i + 1));
    end
    @(negedge clk);
    checkOutput("t3_drained_level", 32'(level), 32'd0);
    @(posedge clk);
    #2;
    rx_ready = 1'b0;

    $display("[TB] partial frame of five bits, then 0x7E");
    clearMonitor();
    startFrame();
    applyStimulus(8'hB0, 5);
    endFrame();
    checkOutput("t4_frame_err", 32'(frameErrCycles), 32'd1);
    checkOutput("t4_level", 32'(level), 32'd0);
`ifdef SPI_RX_OVF_CNT_EN
    checkOutput("t4_ovf_count", 32'(ovf_count), 32'd2);
`endif
    startFrame();
    applyStimulus(8'h7E, 8);
    endFrame();
    checkOutput("t4_next_level", 32'(level), 32'd1);
    checkOutput("t4_next_data", 32'(rx_data), 32'h7E);
    checkOutput("t4_no_new_err", 32'(frameErrCycles), 32'd1);
    popOne();

    $display("[TB] reset in mid-frame with CS held low");
    startFrame();
    applyStimulus(8'hFF, 3);
    rst_n = 1'b0;
    #20;
    rst_n = 1'b1;
    clearMonitor();
    applyStimulus(8'hA5, 8);
    repeat (8) @(posedge clk);
    #2;
    checkOutput("t5_locked_level", 32'(level), 32'd0);
    checkOutput("t5_locked_valid", 32'(rx_valid), 32'h0);
    checkOutput("t5_locked_err", 32'(frameErrCycles), 32'd0);
    CS = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    startFrame();
    applyStimulus(8'hC3, 8);
    endFrame();
    checkOutput("t5_level", 32'(level), 32'd1);
    checkOutput("t5_data", 32'(rx_data), 32'hC3);
    checkOutput("t5_err", 32'(frameErrCycles), 32'd0);
`ifdef SPI_RX_OVF_CNT_EN
    checkOutput("t5_ovf_count", 32'(ovf_count), 32'd0);
`endif
    popOne();

    // The last SCK rise lands 2 ns after edge P; its push is at P+30, so
    // rx_ready raised at P+22 makes the first pop coincide with that push.
    $display("[TB] push into full FIFO coinciding with a pop");
    clearMonitor();
    startFrame();
    applyStimulus(8'hD1, 8);
    applyStimulus(8'hD2, 8);
    applyStimulus(8'hD3, 8);
    applyStimulus(8'hD4, 8);
    checkOutput("t6_full_level", 32'(level), 32'd4);
    applyStimulus(8'hD5, 7);
    MOSI = 1'b1;
    halfPhase();
    SCK = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rx_ready = 1'b1;
    @(negedge clk);
    checkOutput("t6_pre_level", 32'(level), 32'd4);
    checkOutput("t6_pre_head", 32'(rx_data), 32'hD1);
    @(negedge clk);
    checkOutput("t6_post_level", 32'(level), 32'd4);
    checkOutput("t6_post_ovf", 32'(ovf), 32'h0);
    for (int i = 2; i <= 5; i++) begin
      checkOutput($sformatf("t6_order%0d", i), 32'(rx_data), 32'hD0 + i);
      @(negedge clk);
    end
    checkOutput("t6_empty_valid", 32'(rx_valid), 32'h0);
    @(posedge clk);
    #2;
    rx_ready = 1'b0;
    SCK = 1'b0;
    endFrame();
    checkOutput("t6_ovf_cycles", 32'(ovfCycles), 32'd0);
    checkOutput("t6_frame_err", 32'(frameErrCycles), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
